// File: rtl/legv8_multicycle_ctrl_if.sv
// rtl/legv8_multicycle_ctrl_if.sv - opcode/handshake in, datapath controls out, for the LEGv8 multicycle controller
interface legv8_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [10:0]      Op;
  logic             mem_ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             PCSrc;
  logic             Reg2Loc;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             Branch;
  logic             retire;
  logic             fault;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  Op, mem_ready,
    output PCWrite, IRWrite, PCSrc, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp,
           MemRead, MemWrite, MemtoReg, RegWrite, Branch, retire, fault, instr_count
  );

  modport slave (
    output Op, mem_ready,
    input  PCWrite, IRWrite, PCSrc, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp,
           MemRead, MemWrite, MemtoReg, RegWrite, Branch, retire, fault, instr_count
  );
endinterface

// File: rtl/legv8_multicycle_ctrl.sv
// rtl/legv8_multicycle_ctrl.sv - LEGv8 multicycle main control FSM with memory watchdog and retire counter
module legv8_multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int WAIT_W  = 4,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  legv8_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_LDWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_CBZ, S_BR, S_FAULT
  } state_t;

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  state_t            state, next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic [CNT_W-1:0]  count;
  logic              waiting;

  logic       pc_write, ir_write, pc_src, reg2loc, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       mem_read, mem_write, mem_to_reg, reg_write, branch;
  logic       retire_int, fault_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      count    <= '0;
    end else begin
      state    <= next;
      wait_cnt <= wait_next;
      if (retire_int) count <= count + 1'b1;
    end
  end

  always_comb begin
    next       = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    retire_int = 1'b0;
    fault_int  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          next     = S_DECODE;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          next = S_FAULT;
        end
      end
      S_DECODE: begin
        // ALUOut latches PC+4+imm<<2 here so branch states can use it directly
        alu_src_b = 2'b11;
        casez (bus.Op)
          11'b11111000010,
          11'b11111000000: next = S_MEMADR;
          11'b10110100???: next = S_CBZ;
          11'b000101?????: next = S_BR;
          11'b1001000100?: next = S_EXECI;
          11'b???0101?000: next = S_EXECR;
          default:         next = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next      = bus.Op[1] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        if (bus.mem_ready)                next = S_LDWB;
        else if (wait_cnt == TIMEOUT_CNT) next = S_FAULT;
      end
      S_LDWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_int = 1'b1;
        next       = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        reg2loc   = 1'b1;
        if (bus.mem_ready) begin
          retire_int = 1'b1;
          next       = S_FETCH;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          next = S_FAULT;
        end
      end
      S_EXECR: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        next      = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next      = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        retire_int = 1'b1;
        next       = S_FETCH;
      end
      S_CBZ: begin
        reg2loc    = 1'b1;
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        branch     = 1'b1;
        pc_src     = 1'b1;
        retire_int = 1'b1;
        next       = S_FETCH;
      end
      S_BR: begin
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        retire_int = 1'b1;
        next       = S_FETCH;
      end
      S_FAULT: fault_int = 1'b1;
      default: next = S_FAULT;
    endcase
  end

  // Any state change restarts the watchdog, so each memory state gets a fresh budget
  always_comb begin
    waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    if (next != state)                    wait_next = '0;
    else if (waiting && !bus.mem_ready)   wait_next = wait_cnt + 1'b1;
    else                                  wait_next = wait_cnt;
  end

  assign {bus.PCWrite, bus.IRWrite, bus.PCSrc, bus.Reg2Loc, bus.ALUSrcA, bus.ALUSrcB,
          bus.ALUOp, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegWrite, bus.Branch,
          bus.retire, bus.fault} =
    reset ? 16'd0 :
            {pc_write, ir_write, pc_src, reg2loc, alu_src_a, alu_src_b,
             alu_op, mem_read, mem_write, mem_to_reg, reg_write, branch,
             retire_int, fault_int};

  assign bus.instr_count = reset ? '0 : count;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb/tb_legv8_multicycle_ctrl.sv - directed scoreboard bench for legv8_multicycle_ctrl
module tb_legv8_multicycle_ctrl;

  localparam logic [15:0] B_PCW    = 16'h8000;
  localparam logic [15:0] B_IRW    = 16'h4000;
  localparam logic [15:0] B_PCSRC  = 16'h2000;
  localparam logic [15:0] B_R2L    = 16'h1000;
  localparam logic [15:0] B_ASA    = 16'h0800;
  localparam logic [15:0] B_ASB_01 = 16'h0200;
  localparam logic [15:0] B_ASB_10 = 16'h0400;
  localparam logic [15:0] B_ASB_11 = 16'h0600;
  localparam logic [15:0] B_AOP_01 = 16'h0080;
  localparam logic [15:0] B_AOP_10 = 16'h0100;
  localparam logic [15:0] B_MR     = 16'h0040;
  localparam logic [15:0] B_MW     = 16'h0020;
  localparam logic [15:0] B_M2R    = 16'h0010;
  localparam logic [15:0] B_RW     = 16'h0008;
  localparam logic [15:0] B_BR     = 16'h0004;
  localparam logic [15:0] B_RET    = 16'h0002;
  localparam logic [15:0] B_FLT    = 16'h0001;

  localparam logic [15:0] W_ZERO       = 16'h0000;
  localparam logic [15:0] W_FETCH_WAIT = B_MR | B_ASB_01;
  localparam logic [15:0] W_FETCH_RDY  = B_MR | B_ASB_01 | B_PCW | B_IRW;
  localparam logic [15:0] W_DECODE     = B_ASB_11;
  localparam logic [15:0] W_MEMADR     = B_ASA | B_ASB_10;
  localparam logic [15:0] W_MEMRD      = B_MR;
  localparam logic [15:0] W_LDWB       = B_RW | B_M2R | B_RET;
  localparam logic [15:0] W_MEMWR      = B_MW | B_R2L;
  localparam logic [15:0] W_MEMWR_RDY  = B_MW | B_R2L | B_RET;
  localparam logic [15:0] W_EXECR      = B_ASA | B_AOP_10;
  localparam logic [15:0] W_EXECI      = B_ASA | B_ASB_10;
  localparam logic [15:0] W_ALUWB      = B_RW | B_RET;
  localparam logic [15:0] W_CBZ        = B_R2L | B_ASA | B_AOP_01 | B_BR | B_PCSRC | B_RET;
  localparam logic [15:0] W_BR         = B_PCW | B_PCSRC | B_RET;
  localparam logic [15:0] W_FAULT      = B_FLT;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_ILL  = 11'b11111111111;

  typedef struct {
    string       tag;
    logic        rst;
    logic        rdy;
    logic [10:0] op;
    logic [15:0] word;
    logic [3:0]  cnt;
  } entry_t;

  logic        clk;
  logic        reset;
  int          checks;
  int          errors;
  logic [3:0]  exp_cnt;
  logic [10:0] cur_op;
  entry_t      sb[$];

  legv8_multicycle_ctrl_if #(.CNT_W(4)) bus ();

  legv8_multicycle_ctrl #(.TIMEOUT(15), .WAIT_W(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic rst, input logic rdy, input logic [15:0] w);
    entry_t e;
    e.tag  = tag;
    e.rst  = rst;
    e.rdy  = rdy;
    e.op   = cur_op;
    e.word = w;
    if (rst) begin
      e.cnt   = 4'd0;
      exp_cnt = 4'd0;
    end else begin
      e.cnt = exp_cnt;
      if ((w & B_RET) != 16'd0) exp_cnt = exp_cnt + 4'd1;
    end
    sb.push_back(e);
  endtask

  task automatic drain();
    entry_t      e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset         = e.rst;
      bus.mem_ready = e.rdy;
      bus.Op        = e.op;
      #1;
      obs = {bus.PCWrite, bus.IRWrite, bus.PCSrc, bus.Reg2Loc, bus.ALUSrcA, bus.ALUSrcB,
             bus.ALUOp, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegWrite, bus.Branch,
             bus.retire, bus.fault};
      checks++;
      assert (obs === e.word) else begin
        errors++;
        $error("FAIL %s ctrl: observed %h expected %h", e.tag, obs, e.word);
      end
      checks++;
      assert (bus.instr_count === e.cnt) else begin
        errors++;
        $error("FAIL %s instr_count: observed %0d expected %0d", e.tag, bus.instr_count, e.cnt);
      end
    end
  endtask

  task automatic push_alu(input string tag, input logic [10:0] op, input logic [15:0] exec_w);
    cur_op = op;
    push({tag, "_fetch"}, 1'b0, 1'b1, W_FETCH_RDY);
    push({tag, "_decode"}, 1'b0, 1'b1, W_DECODE);
    push({tag, "_exec"}, 1'b0, 1'b1, exec_w);
    push({tag, "_wb"}, 1'b0, 1'b1, W_ALUWB);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    exp_cnt       = 4'd0;
    cur_op        = 11'd0;
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.Op        = 11'd0;

    push("reset0", 1'b1, 1'b1, W_ZERO);
    push("reset1", 1'b1, 1'b1, W_ZERO);

    push_alu("add", OP_ADD, W_EXECR);

    cur_op = OP_LDUR;
    push("ldur_fetch", 1'b0, 1'b1, W_FETCH_RDY);
    push("ldur_decode", 1'b0, 1'b1, W_DECODE);
    push("ldur_memadr", 1'b0, 1'b0, W_MEMADR);
    for (int i = 0; i < 3; i++) push("ldur_memrd_wait", 1'b0, 1'b0, W_MEMRD);
    push("ldur_memrd_rdy", 1'b0, 1'b1, W_MEMRD);
    push("ldur_ldwb", 1'b0, 1'b0, W_LDWB);

    cur_op = OP_B;
    push("b_fetch", 1'b0, 1'b1, W_FETCH_RDY);
    push("b_decode", 1'b0, 1'b1, W_DECODE);
    push("b_br", 1'b0, 1'b1, W_BR);
    cur_op = OP_CBZ;
    push("cbz_fetch", 1'b0, 1'b1, W_FETCH_RDY);
    push("cbz_decode", 1'b0, 1'b1, W_DECODE);
    push("cbz_exec", 1'b0, 1'b1, W_CBZ);

    cur_op = OP_ADDI;
    push("fetch_wait0", 1'b0, 1'b0, W_FETCH_WAIT);
    push("fetch_wait1", 1'b0, 1'b0, W_FETCH_WAIT);
    push("addi_fetch", 1'b0, 1'b1, W_FETCH_RDY);
    push("addi_decode", 1'b0, 1'b1, W_DECODE);
    push("addi_exec", 1'b0, 1'b1, W_EXECI);
    push("addi_wb", 1'b0, 1'b1, W_ALUWB);

    cur_op = OP_STUR;
    push("stur_fetch", 1'b0, 1'b1, W_FETCH_RDY);
    push("stur_decode", 1'b0, 1'b1, W_DECODE);
    push("stur_memadr", 1'b0, 1'b0, W_MEMADR);
    for (int i = 0; i < 15; i++) push("stur_edge_wait", 1'b0, 1'b0, W_MEMWR);
    push("stur_edge_rdy", 1'b0, 1'b1, W_MEMWR_RDY);
    drain();

    push("reset_wrap", 1'b1, 1'b1, W_ZERO);
    for (int i = 0; i < 16; i++) push_alu("addi_wrap", OP_ADDI, W_EXECI);

    cur_op = OP_LDUR;
    push("mid_fetch", 1'b0, 1'b1, W_FETCH_RDY);
    push("mid_decode", 1'b0, 1'b1, W_DECODE);
    push("mid_reset", 1'b1, 1'b1, W_ZERO);
    push("mid_refetch", 1'b0, 1'b0, W_FETCH_WAIT);
    push("mid_fetch2", 1'b0, 1'b1, W_FETCH_RDY);

    cur_op = OP_ILL;
    push("ill_decode", 1'b0, 1'b1, W_DECODE);
    push("ill_fault0", 1'b0, 1'b1, W_FAULT);
    push("ill_fault1", 1'b0, 1'b0, W_FAULT);
    push("ill_fault2", 1'b0, 1'b1, W_FAULT);
    drain();

    push("reset_to", 1'b1, 1'b0, W_ZERO);
    cur_op = OP_STUR;
    push("to_fetch", 1'b0, 1'b1, W_FETCH_RDY);
    push("to_decode", 1'b0, 1'b1, W_DECODE);
    push("to_memadr", 1'b0, 1'b0, W_MEMADR);
    for (int i = 0; i < 16; i++) push("to_memwr_wait", 1'b0, 1'b0, W_MEMWR);
    push("to_fault0", 1'b0, 1'b0, W_FAULT);
    push("to_fault1", 1'b0, 1'b1, W_FAULT);
    push("to_fault2", 1'b0, 1'b0, W_FAULT);
    push("to_reset", 1'b1, 1'b0, W_ZERO);
    push("to_after", 1'b0, 1'b0, W_FETCH_WAIT);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
